drp_adc_responder: RTL and testbench
====================================

DRP_ADC_RESPONDER -- requirements
Module: drp_adc_responder

Interface
REQ-001 Parameter LATENCY, default 4: cycles from DRP request acceptance to drdy_out pulse; legal range 1..15.
REQ-002 clk  input  1  sole clock; all logic rising-edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 daddr_in  input  8  DRP register address; full 8 bits decoded.
REQ-005 den_in  input  1  DRP request enable; may be held high continuously.
REQ-006 dwe_in  input  1  DRP write enable, qualified by den_in.
REQ-007 di_in  input  16  DRP write data.
REQ-008 do_out  output  16  DRP read data, valid when drdy_out=1.
REQ-009 drdy_out  output  1  single-cycle transaction-complete pulse.
REQ-010 sample_valid  input  1  new conversion result present this cycle.
REQ-011 sample_chan  input  4  aux channel index 0..15 of the sample.
REQ-012 sample_data  input  12  unsigned conversion result.
REQ-013 busy  output  1  high while a DRP transaction is outstanding.

Function
REQ-014 Register map: 8'h10+n = aux channel n result, read-only, stored as {sample_data,4'h0}; 8'h40 = general config, R/W; 8'h49 = aux channel enable mask, R/W; all other addresses read 16'h0000 and ignore writes.
REQ-015 FSM states IDLE and BUSY; IDLE->BUSY on a clock edge with den_in=1; BUSY->IDLE on the edge that asserts drdy_out.
REQ-016 Acceptance occurs only in IDLE; den_in in BUSY is ignored, with no queuing.
REQ-017 At acceptance, address, dwe_in and di_in are latched; subsequent bus changes do not affect the transaction.
REQ-018 drdy_out is high for exactly one cycle, LATENCY cycles after the acceptance edge; busy is high from the acceptance edge until the drdy_out edge, inclusive of the drdy_out cycle.
REQ-019 With den_in held high, a new request is accepted on the first edge after the drdy_out cycle; back-to-back period = LATENCY+1 cycles.
REQ-020 Read data is captured at the acceptance edge and presented on do_out together with drdy_out; do_out holds that value until the next read completes.
REQ-021 Write commit occurs at the acceptance edge for 8'h40/8'h49; drdy_out still pulses after LATENCY; do_out is unchanged by writes.
REQ-022 Writes to read-only or unmapped addresses complete normally (drdy_out pulse) with no state change.
REQ-023 On sample_valid=1, channel register sample_chan is updated on that edge only if mask bit sample_chan is 1; masked samples are dropped.
REQ-024 A sample update and a read of the same channel accepted on the same edge return the pre-update value.
REQ-025 A mask write and a sample on the same edge use the pre-write mask for that sample.
REQ-026 Internal latency counter is 4 bits, loads LATENCY-1 at acceptance, decrements in BUSY, and never wraps.

Reset
REQ-027 Asserting rst (low) at any time, including mid-transaction, forces IDLE, drdy_out=0, busy=0, do_out=16'h0000, all channel registers=16'h0000, 8'h40=16'h0000, 8'h49=16'hFFFF; an aborted transaction never produces drdy_out.
REQ-028 After release, the first acceptance occurs on the first edge where rst=1 and den_in=1.

Structure
REQ-029 Shared package drp_pkg holds the address constants (AUX_BASE=8'h10, CFG0=8'h40, AUX_MASK=8'h49), the default LATENCY, and the IDLE/BUSY state enum.
REQ-030 The block is a single module with no sub-modules; the channel store is a 16x16 register array.

Verification
REQ-031 Reset, sample chan 3 = 12'hABC, then den_in pulse at 8'h13 -> drdy_out exactly 4 cycles later with do_out=16'hABC0.
REQ-032 den_in held high, addresses alternating 8'h13/8'h1B, chans 3/11 loaded with 12'h123/12'h7FF -> drdy_out every 5 cycles, data 16'h1230, 16'h7FF0 alternating.
REQ-033 Write 16'hFFF7 to 8'h49, then sample chan 3 = 12'h555 -> read 8'h13 returns the prior value; read 8'h49 returns 16'hFFF7.
REQ-034 Sample chan 11 = 12'h100 on the same edge as acceptance of a read of 8'h1B (old 16'h0000) -> do_out=16'h0000; the next read returns 16'h1000.
REQ-035 Assert rst 2 cycles after acceptance -> no drdy_out; busy=0; 8'h49 reads 16'hFFFF after release.
REQ-036 Read 8'h20 and write 8'h13 -> drdy_out pulses; read data 16'h0000; channel 3 unchanged.

Source files
------------

// File: rtl/drp_pkg.sv
// Shared constants and state type for the DRP ADC responder.
// Register addresses, default latency and FSM encoding.
package drp_pkg;

    localparam logic [7:0] AUX_BASE = 8'h10;
    localparam logic [7:0] CFG0 = 8'h40;
    localparam logic [7:0] AUX_MASK = 8'h49;
    localparam int LATENCY_DEF = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/drp_adc_responder.sv
// DRP slave exposing ADC aux-channel results plus config and mask registers.
// Fixed-latency responder: one outstanding transaction, no queuing.
module drp_adc_responder
    import drp_pkg::*;
#(
    parameter int LATENCY = LATENCY_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  daddr_in,
    input  logic        den_in,
    input  logic        dwe_in,
    input  logic [15:0] di_in,
    output logic [15:0] do_out,
    output logic        drdy_out,
    input  logic        sample_valid,
    input  logic [3:0]  sample_chan,
    input  logic [11:0] sample_data,
    output logic        busy
);

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t      state;
    logic [3:0]  cnt;
    logic        rd_q;
    logic [15:0] rdata_q;
    logic [15:0] cfg0;
    logic [15:0] mask;
    logic [15:0] chan [16];
    logic [15:0] rd_data;

    // Read mux sees pre-edge register values, so same-edge updates are not visible.
    always_comb begin
        rd_data = 16'h0000;
        if (daddr_in[7:4] == AUX_BASE[7:4]) begin
            rd_data = chan[daddr_in[3:0]];
        end else if (daddr_in == CFG0) begin
            rd_data = cfg0;
        end else if (daddr_in == AUX_MASK) begin
            rd_data = mask;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            rd_q     <= 1'b0;
            rdata_q  <= 16'h0000;
            do_out   <= 16'h0000;
            drdy_out <= 1'b0;
            busy     <= 1'b0;
            cfg0     <= 16'h0000;
            mask     <= 16'hFFFF;
            for (int i = 0; i < 16; i++) begin
                chan[i] <= 16'h0000;
            end
        end else begin
            drdy_out <= 1'b0;
            if (sample_valid && mask[sample_chan]) begin
                chan[sample_chan] <= {sample_data, 4'h0};
            end
            unique case (state)
                IDLE: begin
                    busy <= den_in;
                    if (den_in) begin
                        state   <= BUSY;
                        cnt     <= CNT_LOAD;
                        rd_q    <= !dwe_in;
                        rdata_q <= rd_data;
                        if (dwe_in && daddr_in == CFG0) begin
                            cfg0 <= di_in;
                        end
                        if (dwe_in && daddr_in == AUX_MASK) begin
                            mask <= di_in;
                        end
                    end
                end
                BUSY: begin
                    busy <= 1'b1;
                    if (cnt == 4'd0) begin
                        state    <= IDLE;
                        drdy_out <= 1'b1;
                        if (rd_q) begin
                            do_out <= rdata_q;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_drp_adc_responder.sv
// Directed bench for drp_adc_responder: table of DRP/sample ops
// plus hand sequences for back-to-back, reset abort and same-edge hazards.
module tb_drp_adc_responder;

    localparam int LAT = 4;

    logic        clk;
    logic        rst;
    logic [7:0]  daddr_in;
    logic        den_in;
    logic        dwe_in;
    logic [15:0] di_in;
    logic [15:0] do_out;
    logic        drdy_out;
    logic        sample_valid;
    logic [3:0]  sample_chan;
    logic [11:0] sample_data;
    logic        busy;

    int checks = 0;
    int failures = 0;

    drp_adc_responder #(.LATENCY(LAT)) dut (
        .clk(clk),
        .rst(rst),
        .daddr_in(daddr_in),
        .den_in(den_in),
        .dwe_in(dwe_in),
        .di_in(di_in),
        .do_out(do_out),
        .drdy_out(drdy_out),
        .sample_valid(sample_valid),
        .sample_chan(sample_chan),
        .sample_data(sample_data),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        is_sample;
        logic [7:0]  addr;
        logic        we;
        logic [15:0] data;
        logic [15:0] exp_do;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Caller is #1 after an edge; request is accepted on the next edge.
    task automatic xact(input string name, input logic [7:0] a,
                        input logic w, input logic [15:0] d,
                        input logic [15:0] exp_do);
        int n;
        daddr_in = a;
        dwe_in = w;
        di_in = d;
        den_in = 1'b1;
        @(posedge clk);
        #1;
        den_in = 1'b0;
        sample_valid = 1'b0;
        daddr_in = 8'hEE;
        dwe_in = ~w;
        di_in = 16'h5A5A;
        chk({name, "_busy"}, 32'(busy), 32'd1);
        n = 0;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            #1;
            if (drdy_out) begin
                n = k;
                break;
            end
        end
        chk({name, "_lat"}, 32'(n), 32'(LAT));
        if (n != 0) begin
            chk({name, "_do"}, 32'(do_out), 32'(exp_do));
            chk({name, "_busy_drdy"}, 32'(busy), 32'd1);
            @(posedge clk);
            #1;
            chk({name, "_pulse"}, 32'({drdy_out, busy}), 32'd0);
        end
    endtask

    task automatic sample(input logic [3:0] c, input logic [11:0] d);
        sample_chan = c;
        sample_data = d;
        sample_valid = 1'b1;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        daddr_in = 8'h00;
        den_in = 1'b0;
        dwe_in = 1'b0;
        di_in = 16'h0000;
        sample_valid = 1'b0;
        sample_chan = 4'd0;
        sample_data = 12'h000;

        tbl.push_back('{1'b1, 8'h03, 1'b0, 16'h0ABC, 16'h0000});
        tbl.push_back('{1'b0, 8'h13, 1'b0, 16'h0000, 16'hABC0});
        tbl.push_back('{1'b0, 8'h40, 1'b1, 16'h1234, 16'hABC0});
        tbl.push_back('{1'b0, 8'h40, 1'b0, 16'h0000, 16'h1234});
        tbl.push_back('{1'b0, 8'h49, 1'b1, 16'hFFF7, 16'h1234});
        tbl.push_back('{1'b1, 8'h03, 1'b0, 16'h0555, 16'h0000});
        tbl.push_back('{1'b0, 8'h13, 1'b0, 16'h0000, 16'hABC0});
        tbl.push_back('{1'b0, 8'h49, 1'b0, 16'h0000, 16'hFFF7});
        tbl.push_back('{1'b0, 8'h20, 1'b0, 16'h0000, 16'h0000});
        tbl.push_back('{1'b0, 8'h13, 1'b1, 16'hBEEF, 16'h0000});
        tbl.push_back('{1'b0, 8'h13, 1'b0, 16'h0000, 16'hABC0});
        tbl.push_back('{1'b0, 8'h41, 1'b1, 16'hCAFE, 16'hABC0});
        tbl.push_back('{1'b0, 8'h41, 1'b0, 16'h0000, 16'h0000});
        tbl.push_back('{1'b0, 8'h49, 1'b1, 16'hFFFF, 16'h0000});
        tbl.push_back('{1'b1, 8'h03, 1'b0, 16'h0123, 16'h0000});
        tbl.push_back('{1'b1, 8'h0B, 1'b0, 16'h07FF, 16'h0000});
        tbl.push_back('{1'b0, 8'h1B, 1'b0, 16'h0000, 16'h7FF0});

        repeat (3) @(posedge clk);
        #1;
        chk("rst_do", 32'(do_out), 32'h0);
        chk("rst_drdy", 32'(drdy_out), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].is_sample) begin
                sample(tbl[i].addr[3:0], tbl[i].data[11:0]);
            end else begin
                xact($sformatf("vec%0d", i), tbl[i].addr, tbl[i].we,
                     tbl[i].data, tbl[i].exp_do);
            end
        end

        // Back-to-back with den held high: period LAT+1, alternating channels.
        begin
            int k;
            k = 0;
            daddr_in = 8'h13;
            dwe_in = 1'b0;
            den_in = 1'b1;
            for (int e = 0; e < 4 * (LAT + 1); e++) begin
                @(posedge clk);
                #1;
                chk($sformatf("b2b_drdy%0d", e), 32'(drdy_out),
                    32'(e % (LAT + 1) == LAT));
                if (drdy_out) begin
                    chk($sformatf("b2b_do%0d", k), 32'(do_out),
                        (k % 2 == 0) ? 32'h1230 : 32'h7FF0);
                    k++;
                    daddr_in = (k % 2 == 0) ? 8'h13 : 8'h1B;
                    if (k == 4) den_in = 1'b0;
                end
            end
            @(posedge clk);
            #1;
            chk("b2b_idle", 32'({drdy_out, busy}), 32'h0);
        end

        // Reset two cycles after acceptance aborts the transaction.
        daddr_in = 8'h13;
        den_in = 1'b1;
        @(posedge clk);
        #1;
        den_in = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_drdy", 32'(drdy_out), 32'h0);
        chk("abort_do", 32'(do_out), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        begin
            logic seen;
            seen = 1'b0;
            for (int e = 0; e < 2 * LAT; e++) begin
                @(posedge clk);
                #1;
                seen = seen | drdy_out | busy;
            end
            chk("abort_quiet", 32'(seen), 32'h0);
        end
        xact("mask_rst", 8'h49, 1'b0, 16'h0, 16'hFFFF);

        // Sample landing on the acceptance edge of a read of the same channel.
        sample_chan = 4'd11;
        sample_data = 12'h100;
        sample_valid = 1'b1;
        xact("same_edge", 8'h1B, 1'b0, 16'h0, 16'h0000);
        xact("after_edge", 8'h1B, 1'b0, 16'h0, 16'h1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
